// File: rtl/memory_read_sequencer_pkg.sv
// memory_read_sequencer_pkg: shared state encoding for the read sequencer.
// Holds the state-flag width and the Idle..Done codes so that the phase
// controller and debug logic decode PresentStateFlag identically.
package memory_read_sequencer_pkg;
   localparam int STATE_FLAG_WIDTH = 3;
   typedef enum logic [STATE_FLAG_WIDTH-1:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      SHOW  = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/memory_read_sequencer_hold_timer.sv
// memory_read_sequencer_hold_timer: loadable down-counter with a zero flag.
// Ports: clock1Hz tick clock; reset async active-high (count=0);
//   load loads loadvalue (wins over decrement); decrement counts down,
//   saturating at 0; zero is high when the count is 0.
module memory_read_sequencer_hold_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clock1Hz,
   input  logic             reset,
   input  logic             load,
   input  logic             decrement,
   input  logic [WIDTH-1:0] loadvalue,
   output logic             zero
);
   logic [WIDTH-1:0] count;
   assign zero = (count == '0);
   always_ff @(posedge clock1Hz or posedge reset)
      if (reset) count <= '0;
      else if (load) count <= loadvalue;
      else if (decrement && !zero) count <= count - WIDTH'(1);
endmodule

// File: rtl/memory_read_sequencer.sv
// memory_read_sequencer: replays memory words 0..count-1 after a write phase.
// Ports: clock1Hz tick clock; reset async active-high; ReadStart/WordCount
//   start request and word count (sampled in Idle only); MemAddr/MemReadEnable
//   read address and one-cycle strobe; MemData synchronous read data;
//   DataOut/DataValid captured word and its valid flag (HOLD_TICKS cycles);
//   ReadDone one-cycle completion pulse; Busy high outside Idle;
//   PresentStateFlag encoded current state.
module memory_read_sequencer
   import memory_read_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int HOLD_TICKS = 2
) (
   input  logic                        clock1Hz,
   input  logic                        reset,
   input  logic                        ReadStart,
   input  logic [ADDR_WIDTH:0]         WordCount,
   output logic [ADDR_WIDTH-1:0]       MemAddr,
   output logic                        MemReadEnable,
   input  logic [DATA_WIDTH-1:0]       MemData,
   output logic [DATA_WIDTH-1:0]       DataOut,
   output logic                        DataValid,
   output logic                        ReadDone,
   output logic                        Busy,
   output logic [STATE_FLAG_WIDTH-1:0] PresentStateFlag
);
   localparam logic [ADDR_WIDTH:0] ONE = 1;
   state_t state;
   logic [ADDR_WIDTH:0] count;
   logic holdzero;
   assign PresentStateFlag = state;
   // Loaded on the edge leaving Latch so Show lasts exactly HOLD_TICKS cycles.
   memory_read_sequencer_hold_timer #(.WIDTH(8)) holdtimer (
      .clock1Hz  (clock1Hz),
      .reset     (reset),
      .load      (state == LATCH),
      .decrement (state == SHOW),
      .loadvalue (8'(HOLD_TICKS - 1)),
      .zero      (holdzero)
   );
   // Outputs are registered: each branch sets the values belonging to the
   // state being entered.
   always_ff @(posedge clock1Hz or posedge reset)
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         MemAddr       <= '0;
         MemReadEnable <= 1'b0;
         DataOut       <= '0;
         DataValid     <= 1'b0;
         ReadDone      <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (ReadStart) begin
                  count   <= WordCount;
                  MemAddr <= '0;
                  Busy    <= 1'b1;
                  if (WordCount != '0) begin
                     state         <= FETCH;
                     MemReadEnable <= 1'b1;
                  end else begin
                     state    <= DONE;
                     ReadDone <= 1'b1;
                  end
               end
            FETCH: begin
               state         <= LATCH;
               MemReadEnable <= 1'b0;
            end
            LATCH: begin
               state     <= SHOW;
               DataOut   <= MemData;
               DataValid <= 1'b1;
            end
            SHOW:
               if (holdzero) begin
                  DataValid <= 1'b0;
                  // Compare at ADDR_WIDTH+1 bits so a full-depth count ends
                  // at the all-ones address instead of wrapping.
                  if ({1'b0, MemAddr} == count - ONE) begin
                     state    <= DONE;
                     ReadDone <= 1'b1;
                  end else begin
                     MemAddr       <= MemAddr + ADDR_WIDTH'(1);
                     state         <= FETCH;
                     MemReadEnable <= 1'b1;
                  end
               end
            DONE: begin
               state    <= IDLE;
               ReadDone <= 1'b0;
               Busy     <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               MemReadEnable <= 1'b0;
               DataValid     <= 1'b0;
               ReadDone      <= 1'b0;
               Busy          <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_memory_read_sequencer.sv
// tb_memory_read_sequencer: randomized self-checking bench for memory_read_sequencer.
module tb_memory_read_sequencer;
   localparam int AW = 4;
   localparam int DW = 8;
   typedef logic [18:0] obs_t;

   logic clock1Hz = 1'b0;
   logic reset = 1'b1;
   logic ReadStart = 1'b0;
   logic [AW:0] WordCount = '0;
   logic [AW-1:0] MemAddr;
   logic MemReadEnable;
   logic [DW-1:0] MemData = '0;
   logic [DW-1:0] DataOut;
   logic DataValid, ReadDone, Busy;
   logic [2:0] PresentStateFlag;

   logic ReadStart1 = 1'b0;
   logic [AW:0] WordCount1 = '0;
   logic [AW-1:0] MemAddr1;
   logic MemReadEnable1;
   logic [DW-1:0] MemData1 = '0;
   logic [DW-1:0] DataOut1;
   logic DataValid1, ReadDone1, Busy1;
   logic [2:0] PresentStateFlag1;

   logic [DW-1:0] mem [16];
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] last_data = '0;
   int tests = 0;
   int failed = 0;
   obs_t obs, exp;

   always #5 clock1Hz = ~clock1Hz;
   always @(posedge clock1Hz) if (MemReadEnable) MemData <= mem[MemAddr];
   always @(posedge clock1Hz) if (MemReadEnable1) MemData1 <= mem[MemAddr1];
   assign obs = {PresentStateFlag, Busy, ReadDone, DataValid, MemReadEnable, MemAddr, DataOut};

   memory_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_TICKS(2)) dut (
      .clock1Hz(clock1Hz), .reset(reset), .ReadStart(ReadStart), .WordCount(WordCount),
      .MemAddr(MemAddr), .MemReadEnable(MemReadEnable), .MemData(MemData),
      .DataOut(DataOut), .DataValid(DataValid), .ReadDone(ReadDone), .Busy(Busy),
      .PresentStateFlag(PresentStateFlag));

   memory_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_TICKS(1)) dut1 (
      .clock1Hz(clock1Hz), .reset(reset), .ReadStart(ReadStart1), .WordCount(WordCount1),
      .MemAddr(MemAddr1), .MemReadEnable(MemReadEnable1), .MemData(MemData1),
      .DataOut(DataOut1), .DataValid(DataValid1), .ReadDone(ReadDone1), .Busy(Busy1),
      .PresentStateFlag(PresentStateFlag1));

   // Expected outputs in cycle c of an n-word replay started at cycle 0,
   // derived from the timing rules: word k occupies cycles 1+k*p .. k*p+p
   // (Fetch, Latch, then h Show cycles) and Done falls at 1+n*p.
   function automatic obs_t model(int c, int n, int h);
      int p = h + 2;
      int k = (c - 1) / p;
      int ph = (c - 1) % p;
      logic [AW-1:0] fa = (n == 0) ? '0 : AW'(n - 1);
      logic [DW-1:0] fd = (n == 0) ? last_data : mem[n-1];
      logic [DW-1:0] d;
      if (c == 0) return {3'd0, 4'b0000, last_addr, last_data};
      if (c > 1 + n * p) return {3'd0, 4'b0000, fa, fd};
      if (c == 1 + n * p) return {3'd4, 4'b1100, fa, fd};
      d = (ph >= 2) ? mem[k] : ((k == 0) ? last_data : mem[k-1]);
      return {3'((ph == 0) ? 1 : (ph == 1) ? 2 : 3), 1'b1, 1'b0, ph >= 2, ph == 0, AW'(k), d};
   endfunction

   task automatic finish_run(int n);
      last_data = (n == 0) ? last_data : mem[n-1];
      last_addr = (n == 0) ? '0 : AW'(n - 1);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock1Hz);
      tests++;
      if (obs !== '0) begin failed++; $display("FAIL reset got %h exp %h", obs, 19'h0); end
      tests++;
      if ({MemReadEnable1, DataValid1, ReadDone1, Busy1, PresentStateFlag1} !== '0) begin
         failed++; $display("FAIL reset1 got %b exp 0", {MemReadEnable1, DataValid1, ReadDone1, Busy1, PresentStateFlag1});
      end
      reset = 1'b0;
      last_addr = '0;
      last_data = '0;
   endtask

   task automatic test_basic();
      int n = 3;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
      for (int c = 0; c <= 2 + n * 4; c++) begin
         if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; end
         exp = model(c, n, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL basic c=%0d got %h exp %h", c, obs, exp); end
      end
      finish_run(n);
   endtask

   task automatic test_empty();
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = '0;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; end
         exp = model(c, 0, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL empty c=%0d got %h exp %h", c, obs, exp); end
      end
      finish_run(0);
   endtask

   task automatic test_full_depth();
      int n = 16;
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
      for (int c = 0; c <= 3 + n * 4; c++) begin
         if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; end
         exp = model(c, n, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL full c=%0d got %h exp %h", c, obs, exp); end
      end
      finish_run(n);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clock1Hz);
         @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
         for (int c = 0; c <= 2 + n * 4; c++) begin
            if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; WordCount = 5'($urandom); end
            exp = model(c, n, 2); tests++;
            if (obs !== exp) begin failed++; $display("FAIL random n=%0d c=%0d got %h exp %h", n, c, obs, exp); end
         end
         finish_run(n);
      end
   endtask

   task automatic test_ignored_restart();
      int n = 4;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
      for (int c = 0; c <= 2 + n * 4; c++) begin
         if (c > 0) begin
            @(negedge clock1Hz);
            ReadStart = (c == 6);
            WordCount = (c == 6) ? 5'd1 : WordCount;
         end
         exp = model(c, n, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL restart c=%0d got %h exp %h", c, obs, exp); end
      end
      ReadStart = 1'b0;
      finish_run(n);
   endtask

   task automatic test_mid_reset();
      int n = 4;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; end
         exp = model(c, n, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL prereset c=%0d got %h exp %h", c, obs, exp); end
      end
      #2 reset = 1'b1;
      #1 tests++;
      if (obs !== '0) begin failed++; $display("FAIL async_reset got %h exp %h", obs, 19'h0); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock1Hz); tests++;
         if (obs !== '0) begin failed++; $display("FAIL held_reset c=%0d got %h exp %h", c, obs, 19'h0); end
      end
      reset = 1'b0;
      last_addr = '0;
      last_data = '0;
      n = 2;
      @(negedge clock1Hz); ReadStart = 1'b1; WordCount = 5'(n);
      for (int c = 0; c <= 2 + n * 4; c++) begin
         if (c > 0) begin @(negedge clock1Hz); ReadStart = 1'b0; end
         exp = model(c, n, 2); tests++;
         if (obs !== exp) begin failed++; $display("FAIL postreset c=%0d got %h exp %h", c, obs, exp); end
      end
      finish_run(n);
   endtask

   // HOLD_TICKS=1, one word, start held high: period 3, Done at 4, Idle at 5,
   // so Fetch recurs every 5 cycles.
   task automatic test_back_to_back();
      logic [2:0] e;
      mem[0] = 8'($urandom);
      @(negedge clock1Hz); ReadStart1 = 1'b1; WordCount1 = 5'd1;
      for (int c = 0; c <= 20; c++) begin
         if (c > 0) @(negedge clock1Hz);
         e = {c >= 1 && (c - 1) % 5 == 0, c % 5 == 4, c % 5 == 3};
         tests++;
         if ({MemReadEnable1, ReadDone1, DataValid1} !== e) begin
            failed++; $display("FAIL b2b c=%0d got %b exp %b", c, {MemReadEnable1, ReadDone1, DataValid1}, e);
         end
         if (e[0] == 1'b1 && c >= 3) begin
            tests++;
            if (DataOut1 !== mem[0]) begin failed++; $display("FAIL b2b_data c=%0d got %h exp %h", c, DataOut1, mem[0]); end
         end
      end
      ReadStart1 = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_basic();
      test_empty();
      test_full_depth();
      test_random();
      test_ignored_restart();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/memory_read_sequencer.md
# memory_read_sequencer

Replays the contents of the data memory after a write phase. On a start request it latches a word count and walks addresses 0..count-1. For each address it issues one read strobe, captures the returned word, and presents it with a valid flag for a fixed number of ticks. It sits between the phase controller (which starts it when the Read phase begins) and the display/output logic. It shares the memory's read port with the controller's write path and uses the same slow tick clock.

## Interface
Parameters:
- ADDR_WIDTH, default 4: memory address width.
- DATA_WIDTH, default 8: memory word width.
- HOLD_TICKS, default 2: clock cycles each word stays valid; legal range 1..255.

Ports:
- clock1Hz  input  1  system tick clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces Idle and all output reset values immediately.
- ReadStart  input  1  start request, sampled only in Idle.
- WordCount  input  ADDR_WIDTH+1  number of words to replay; 0..2^ADDR_WIDTH; sampled with ReadStart.
- MemAddr  output  ADDR_WIDTH  read address to memory.
- MemReadEnable  output  1  read strobe, one cycle per word.
- MemData  input  DATA_WIDTH  memory read data, valid the cycle after MemReadEnable (synchronous read).
- DataOut  output  DATA_WIDTH  captured word.
- DataValid  output  1  DataOut is a current word.
- ReadDone  output  1  one-cycle pulse when the sequence completes.
- Busy  output  1  high in every state except Idle.
- PresentStateFlag  output  3  encoded current state.

## Operation
- States and encoding: Idle=0, Fetch=1, Latch=2, Show=3, Done=4. Codes 5..7 are unreachable and go to Idle on the next edge.
- Idle:
  - All strobes are 0.
  - If ReadStart=1, register WordCount into an internal count and clear the address to 0.
  - Go to Fetch if the count is nonzero, else go to Done.
- Fetch: MemReadEnable=1 at MemAddr. Always go to Latch.
- Latch:
  - MemReadEnable=0.
  - On the edge leaving Latch, DataOut <= MemData and the hold counter <= HOLD_TICKS-1.
  - Go to Show.
- Show:
  - DataValid=1.
  - When the hold counter is 0: if MemAddr == count-1, go to Done; else MemAddr <= MemAddr+1 and go to Fetch.
  - Otherwise decrement the hold counter.
- Done: ReadDone=1 for exactly one cycle, then go to Idle.
- DataOut keeps the last captured word until the next Latch or reset.
- DataValid is 0 outside Show.
- While not in Idle, ReadStart and changes on WordCount are ignored. Only the registered count is used.
- WordCount=2^ADDR_WIDTH is legal. The address runs to all-ones and never wraps past it; the address-compare width is ADDR_WIDTH+1.
- MemAddr holds its value in Done and Idle. It is cleared only by a new start or by reset.

## Timing
- Reset values: MemAddr=0, MemReadEnable=0, DataOut=0, DataValid=0, ReadDone=0, Busy=0, PresentStateFlag=0. The internal count and hold counter are also 0.
- Cycle numbering: cycle 0 is the cycle in which ReadStart=1 is sampled in Idle.
- For word k:
  - Fetch is in cycle 1+k·(HOLD_TICKS+2).
  - Latch follows one cycle after Fetch.
  - DataValid is high for HOLD_TICKS consecutive cycles, starting 2 cycles after Fetch.
- Per-word period is HOLD_TICKS+2 cycles. Done occurs at cycle 1+N·(HOLD_TICKS+2). Busy falls on the following edge.
- N=0: Done is in cycle 1, with no MemReadEnable and no DataValid.
- Reset asserted mid-sequence: every output returns to its reset value asynchronously, with no ReadDone pulse. After release, operation resumes from Idle on the first edge.
- ReadStart held high continuously: a new sequence starts in the Idle cycle after Done. The next Fetch is therefore 2 cycles after Done.

## Structure
- Shared package: the state encoding constants (Idle..Done) and the 3-bit state-flag width, so phase-controller and debug logic decode PresentStateFlag identically.
- Sub-module: one natural sub-module, hold_timer. It is a loadable down-counter with a zero flag, reusable for the controller's timer, and is instantiated here for HOLD_TICKS.
- Everything else, including the address counter, count register and FSM, stays in this module.

## Test plan
- Basic replay: memory preloaded 0x11,0x22,0x33; WordCount=3; HOLD_TICKS=2 -> MemAddr 0,1,2 each strobed once. DataOut 0x11/0x22/0x33 is each valid for 2 cycles. ReadDone occurs at cycle 13, then Busy=0.
- Empty: WordCount=0 with ReadStart -> ReadDone at cycle 1, MemReadEnable never high, DataValid never high.
- Full depth: ADDR_WIDTH=4, WordCount=16, memory[i]=i+0xA0 -> 16 words 0xA0..0xAF in order. MemAddr stops at 15 and DataOut holds 0xAF after Done.
- Ignored restart: during word 1 of a 4-word replay, pulse ReadStart with WordCount=1 -> the sequence still completes 4 words with the original timing.
- Mid-sequence reset: assert reset during Show of word 2 -> all outputs are 0 immediately, with no ReadDone. A restart with WordCount=2 then replays addresses 0,1 correctly.
- Back-to-back: hold ReadStart=1 with WordCount=1 and HOLD_TICKS=1 -> Fetch recurs every 5 cycles with a one-cycle ReadDone each time.
